// File: rtl/elevator_pkg.sv
// Shared types, constants and floor-mask helpers for the elevator SCAN scheduler.
package elevator_pkg;

    localparam int N_FLR      = 4;
    localparam int FLR_W      = 2;
    localparam int DOOR_CYC   = 8;
    localparam int TRAVEL_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_CLOSE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // One bit set at the given floor.
    function automatic logic [N_FLR-1:0] onehot(input logic [FLR_W-1:0] flr);
        logic [N_FLR-1:0] m;
        m      = {N_FLR{1'b0}};
        m[flr] = 1'b1;
        return m;
    endfunction

    // Floors strictly above cur.
    function automatic logic [N_FLR-1:0] above_mask(input logic [FLR_W-1:0] cur);
        logic [N_FLR-1:0] m;
        for (int i = 0; i < N_FLR; i++) begin
            m[i] = (i > int'(cur));
        end
        return m;
    endfunction

    // Floors strictly below cur.
    function automatic logic [N_FLR-1:0] below_mask(input logic [FLR_W-1:0] cur);
        logic [N_FLR-1:0] m;
        for (int i = 0; i < N_FLR; i++) begin
            m[i] = (i < int'(cur));
        end
        return m;
    endfunction

    // Lowest set bit of req (req already restricted to floors above the car).
    function automatic logic [FLR_W-1:0] nearest_above(input logic [N_FLR-1:0] req,
                                                       input logic [FLR_W-1:0] cur);
        logic [FLR_W-1:0] idx;
        idx = cur;
        for (int i = N_FLR - 1; i >= 0; i--) begin
            idx = req[i] ? FLR_W'(i) : idx;
        end
        return idx;
    endfunction

    // Highest set bit of req (req already restricted to floors below the car).
    function automatic logic [FLR_W-1:0] nearest_below(input logic [N_FLR-1:0] req,
                                                       input logic [FLR_W-1:0] cur);
        logic [FLR_W-1:0] idx;
        idx = cur;
        for (int i = 0; i < N_FLR; i++) begin
            idx = req[i] ? FLR_W'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/elevator_scan_pick.sv
// Combinational SCAN target selection: keep sweeping while work lies ahead,
// reverse only when the current direction is exhausted.
module elevator_scan_pick
    import elevator_pkg::*;
(
    input  logic [N_FLR-1:0] pending_i,
    input  logic [FLR_W-1:0] cur_flr_i,
    input  logic             dir_up_i,
    output logic [FLR_W-1:0] nxt_flr_o,
    output logic             dir_next_o,
    output logic             have_target_o,
    output logic             here_o
);

    logic [N_FLR-1:0] above_s;
    logic [N_FLR-1:0] below_s;

    // Split outstanding requests around the car and pick the nearest one in sweep order.
    always_comb begin
        above_s       = pending_i & above_mask(cur_flr_i);
        below_s       = pending_i & below_mask(cur_flr_i);
        here_o        = pending_i[cur_flr_i];
        have_target_o = (|above_s) | (|below_s);
        if (dir_up_i && (|above_s)) begin
            nxt_flr_o  = nearest_above(above_s, cur_flr_i);
            dir_next_o = 1'b1;
        end else if (!dir_up_i && (|below_s)) begin
            nxt_flr_o  = nearest_below(below_s, cur_flr_i);
            dir_next_o = 1'b0;
        end else if (|above_s) begin
            nxt_flr_o  = nearest_above(above_s, cur_flr_i);
            dir_next_o = 1'b1;
        end else if (|below_s) begin
            nxt_flr_o  = nearest_below(below_s, cur_flr_i);
            dir_next_o = 1'b0;
        end else begin
            nxt_flr_o  = cur_flr_i;
            dir_next_o = dir_up_i;
        end
    end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// Elevator sequencer: request latch, SCAN target, motor/door FSM, door timer
// and travel watchdog. Motor commands are additionally interlocked against the
// end floors so the car can never be driven past the shaft limits.
module elevator_scan_scheduler
    import elevator_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_FLR-1:0] fb_req,
    input  logic [N_FLR-1:0] call_req,
    input  logic [FLR_W-1:0] cur_flr,
    input  logic             flr_stb,
    output logic             m_up,
    output logic             m_dn,
    output logic [N_FLR-1:0] door,
    output logic [FLR_W-1:0] nxt_flr,
    output logic [N_FLR-1:0] pending,
    output logic             dir_up,
    output logic             fault
);

    localparam int DOOR_W = $clog2(DOOR_CYC);
    localparam int WD_W   = $clog2(TRAVEL_MAX);
    localparam logic [DOOR_W-1:0] DOOR_RELOAD = DOOR_W'(DOOR_CYC - 1);
    localparam logic [WD_W-1:0]   WD_RELOAD   = WD_W'(TRAVEL_MAX - 1);
    localparam logic [FLR_W-1:0]  TOP_FLR     = FLR_W'(N_FLR - 1);
    localparam logic [FLR_W-1:0]  BOT_FLR     = {FLR_W{1'b0}};

    state_e            state_q, state_d;
    logic [N_FLR-1:0]  pending_q, pending_d;
    logic [FLR_W-1:0]  nxt_flr_q, nxt_flr_d;
    logic              dir_up_q, dir_up_d;
    logic              m_up_q, m_up_d;
    logic              m_dn_q, m_dn_d;
    logic [N_FLR-1:0]  door_q, door_d;
    logic              fault_q, fault_d;
    logic [DOOR_W-1:0] door_tmr_q, door_tmr_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [N_FLR-1:0]  req_s;
    logic [N_FLR-1:0]  clr_mask_s;
    logic [FLR_W-1:0]  pick_nxt_s;
    logic              dir_next_s;
    logic              have_target_s;
    logic              here_s;
    logic              at_end_s;

    elevator_scan_pick u_pick (
        .pending_i     (pending_q),
        .cur_flr_i     (cur_flr),
        .dir_up_i      (dir_up_q),
        .nxt_flr_o     (pick_nxt_s),
        .dir_next_o    (dir_next_s),
        .have_target_o (have_target_s),
        .here_o        (here_s)
    );

    // Next-state logic for the FSM, timers, request latch and registered outputs.
    always_comb begin
        req_s      = fb_req | call_req;
        state_d    = state_q;
        m_up_d     = 1'b0;
        m_dn_d     = 1'b0;
        door_d     = {N_FLR{1'b0}};
        door_tmr_d = door_tmr_q;
        wd_d       = wd_q;
        dir_up_d   = dir_up_q;
        fault_d    = fault_q;
        at_end_s   = dir_up_q ? (cur_flr == TOP_FLR) : (cur_flr == BOT_FLR);

        case (state_q)
            ST_IDLE: begin
                if (here_s) begin
                    state_d    = ST_OPEN;
                    door_d     = onehot(cur_flr);
                    door_tmr_d = DOOR_RELOAD;
                end else if (have_target_s) begin
                    state_d  = ST_MOVE;
                    dir_up_d = dir_next_s;
                    m_up_d   = dir_next_s;
                    m_dn_d   = ~dir_next_s;
                    wd_d     = WD_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                door_d = onehot(cur_flr);
                if (req_s[cur_flr]) begin
                    door_tmr_d = DOOR_RELOAD;
                end else if (door_tmr_q == {DOOR_W{1'b0}}) begin
                    state_d = ST_CLOSE;
                    door_d  = {N_FLR{1'b0}};
                end else begin
                    door_tmr_d = door_tmr_q - DOOR_W'(1);
                end
            end
            ST_CLOSE: begin
                if (here_s) begin
                    state_d    = ST_OPEN;
                    door_d     = onehot(cur_flr);
                    door_tmr_d = DOOR_RELOAD;
                end else if (have_target_s) begin
                    state_d  = ST_MOVE;
                    dir_up_d = dir_next_s;
                    m_up_d   = dir_next_s;
                    m_dn_d   = ~dir_next_s;
                    wd_d     = WD_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if ((flr_stb || at_end_s) && here_s) begin
                    state_d    = ST_OPEN;
                    door_d     = onehot(cur_flr);
                    door_tmr_d = DOOR_RELOAD;
                end else if (at_end_s) begin
                    state_d = ST_CLOSE;
                end else if (flr_stb) begin
                    m_up_d = dir_up_q;
                    m_dn_d = ~dir_up_q;
                    wd_d   = WD_RELOAD;
                end else if (wd_q == {WD_W{1'b0}}) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    m_up_d = dir_up_q;
                    m_dn_d = ~dir_up_q;
                    wd_d   = wd_q - WD_W'(1);
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase

        // A request at the floor whose door is (or is about to be) open is consumed, not latched.
        if ((state_q == ST_OPEN) || (state_d == ST_OPEN)) begin
            clr_mask_s = onehot(cur_flr);
        end else begin
            clr_mask_s = {N_FLR{1'b0}};
        end
        pending_d = (pending_q | req_s) & ~clr_mask_s;
        nxt_flr_d = pick_nxt_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= {N_FLR{1'b0}};
            nxt_flr_q  <= {FLR_W{1'b0}};
            dir_up_q   <= 1'b1;
            m_up_q     <= 1'b0;
            m_dn_q     <= 1'b0;
            door_q     <= {N_FLR{1'b0}};
            fault_q    <= 1'b0;
            door_tmr_q <= {DOOR_W{1'b0}};
            wd_q       <= {WD_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            nxt_flr_q  <= nxt_flr_d;
            dir_up_q   <= dir_up_d;
            m_up_q     <= m_up_d;
            m_dn_q     <= m_dn_d;
            door_q     <= door_d;
            fault_q    <= fault_d;
            door_tmr_q <= door_tmr_d;
            wd_q       <= wd_d;
        end
    end

    // End-floor interlock: the car arriving at a limit floor cuts the motor
    // in the same cycle, before the registered stop takes effect.
    assign m_up    = m_up_q & (cur_flr != TOP_FLR);
    assign m_dn    = m_dn_q & (cur_flr != BOT_FLR);
    assign door    = door_q;
    assign nxt_flr = nxt_flr_q;
    assign pending = pending_q;
    assign dir_up  = dir_up_q;
    assign fault   = fault_q;

endmodule
